// File: rtl/seven_seg_scanner.sv
// ---------------------------------------------------------------------------
// seven_seg_scanner
//
// Purpose:
//   Time-multiplexed driver for a bank of common-anode seven-segment digits
//   that share one segment bus. A packed hex word plus decimal-point and
//   blank masks are captured into shadow registers on 'load'. The digits are
//   then scanned round-robin, one slot of SCAN_DIV clocks each, and the
//   active nibble is decoded to an active-low segment pattern.
//
// Parameters:
//   DIGITS    number of digits scanned (1..16)
//   SCAN_DIV  clk cycles each digit stays lit (>= 2)
//
// Ports:
//   clk         system clock
//   rst         synchronous, active-high reset
//   data        packed nibbles, digit i = data[4i+3:4i], digit 0 rightmost
//   dp_in       decimal point request per digit, 1 = lit
//   blank_in    blank request per digit, 1 = dark
//   load        capture data/dp_in/blank_in into the shadow registers
//   an          anode enables, active-low, at most one bit low
//   segments    {a,b,c,d,e,f,g,dp}, active-low
//   frame_done  one-cycle pulse when the slot of digit DIGITS-1 ends
//
// Optional feature:
//   Define SEVEN_SEG_LZ_SUPPRESS_EN to enable leading-zero suppression.
// ---------------------------------------------------------------------------
module seven_seg_scanner #(
   parameter int DIGITS   = 8,
   parameter int SCAN_DIV = 100000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [4*DIGITS-1:0]   data,
   input  logic [DIGITS-1:0]     dp_in,
   input  logic [DIGITS-1:0]     blank_in,
   input  logic                  load,
   output logic [DIGITS-1:0]     an,
   output logic [7:0]            segments,
   output logic                  frame_done
);

   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int PS_W  = $clog2(SCAN_DIV);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);
   localparam logic [PS_W-1:0]  LAST_PS  = PS_W'(SCAN_DIV - 1);

   logic [PS_W-1:0]     prescaler_q, prescaler_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [4*DIGITS-1:0] data_q, data_d;
   logic [DIGITS-1:0]   dp_q, dp_d;
   logic [DIGITS-1:0]   blank_q, blank_d;
   logic [DIGITS-1:0]   an_q, an_d;
   logic [7:0]          seg_q, seg_d;
   logic                frame_done_q, frame_done_d;

   logic                tick;
   logic [3:0]          sel_nibble;
   logic                sel_dp;
   logic                sel_blank;
   logic [DIGITS-1:0]   lz_mask;

   // Hex nibble to active-low abcdefg pattern (bit6 = a, bit0 = g).
   function automatic logic [6:0] seg_decode(input logic [3:0] nib);
      logic [6:0] pat;
      case (nib)
         4'h0: pat = 7'b0000001;
         4'h1: pat = 7'b1001111;
         4'h2: pat = 7'b0010010;
         4'h3: pat = 7'b0000110;
         4'h4: pat = 7'b1001100;
         4'h5: pat = 7'b0100100;
         4'h6: pat = 7'b0100000;
         4'h7: pat = 7'b0001111;
         4'h8: pat = 7'b0000000;
         4'h9: pat = 7'b0001100;
         4'hA: pat = 7'b0001000;
         4'hB: pat = 7'b1100000;
         4'hC: pat = 7'b1110010;
         4'hD: pat = 7'b1000010;
         4'hE: pat = 7'b0110000;
         4'hF: pat = 7'b0111000;
      endcase
      return pat;
   endfunction

   // Shadow registers: the scan only ever looks at these, never the live inputs.
   always_comb begin
      data_d  = data_q;
      dp_d    = dp_q;
      blank_d = blank_q;
      if (load) begin
         data_d  = data;
         dp_d    = dp_in;
         blank_d = blank_in;
      end
   end

   // Slot timer and digit index. frame_done is registered so it lands on the
   // same cycle that digit 0 lights up.
   always_comb begin
      tick         = (prescaler_q == LAST_PS);
      prescaler_d  = tick ? '0 : prescaler_q + 1'b1;
      idx_d        = idx_q;
      frame_done_d = 1'b0;
      if (tick) begin
         idx_d        = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
         frame_done_d = (idx_q == LAST_IDX);
      end
   end

`ifdef SEVEN_SEG_LZ_SUPPRESS_EN
   // Walk down from the most significant digit; a digit is suppressed while
   // it and every digit above it are zero with no decimal point. Digit 0 is
   // never suppressed so a zero value still shows a single '0'.
   always_comb begin : lz_calc
      logic lead;
      lead    = 1'b1;
      lz_mask = '0;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         lead       = lead && (data_q[4*i +: 4] == 4'h0) && !dp_q[i];
         lz_mask[i] = lead;
      end
   end
`else
   assign lz_mask = '0;
`endif

   // Pick the shadow contents of the digit about to be lit (post-increment
   // index, pre-load shadow values).
   always_comb begin
      sel_nibble = 4'h0;
      sel_dp     = 1'b0;
      sel_blank  = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (idx_d == IDX_W'(i)) begin
            sel_nibble = data_q[4*i +: 4];
            sel_dp     = dp_q[i];
            sel_blank  = blank_q[i] | lz_mask[i];
         end
      end
   end

   // Output registers only move on the tick edge. A blanked digit keeps its
   // anode driven so every slot looks identical in timing.
   always_comb begin
      an_d  = an_q;
      seg_d = seg_q;
      if (tick) begin
         an_d  = ~(DIGITS'(1) << idx_d);
         seg_d = sel_blank ? 8'hFF : {seg_decode(sel_nibble), ~sel_dp};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         prescaler_q  <= '0;
         idx_q        <= '0;
         data_q       <= '0;
         dp_q         <= '0;
         blank_q      <= '0;
         an_q         <= '1;
         seg_q        <= 8'hFF;
         frame_done_q <= 1'b0;
      end else begin
         prescaler_q  <= prescaler_d;
         idx_q        <= idx_d;
         data_q       <= data_d;
         dp_q         <= dp_d;
         blank_q      <= blank_d;
         an_q         <= an_d;
         seg_q        <= seg_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign an         = an_q;
   assign segments   = seg_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// ---------------------------------------------------------------------------
// tb_seven_seg_scanner
//
// Self-checking bench for seven_seg_scanner with DIGITS=4, SCAN_DIV=4.
// The stimulus process loads shadow words at chosen clock edges and queues
// the hand-computed {an, segments} expected for each upcoming scan slot.
// A monitor pops one entry each time the anode pattern changes and also
// checks frame_done timing, one-hot-low anodes and segment stability.
// ---------------------------------------------------------------------------
module tb_seven_seg_scanner;

   localparam int DIGITS   = 4;
   localparam int SCAN_DIV = 4;

`ifdef SEVEN_SEG_LZ_SUPPRESS_EN
   localparam logic [7:0] ZU = 8'hFF;
`else
   localparam logic [7:0] ZU = 8'h03;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        load = 1'b0;
   logic [15:0] data = 16'h0000;
   logic [3:0]  dpIn = 4'h0;
   logic [3:0]  blankIn = 4'h0;
   logic [3:0]  an;
   logic [7:0]  segments;
   logic        frameDone;

   int          assertCount = 0;
   int          failCount = 0;
   int          edgeCnt = 0;
   int          rstAt;
   bit          monitorOn = 1'b0;
   logic [11:0] expQ[$];
   logic [11:0] monExp;
   logic [3:0]  prevAn = 4'hF;
   logic [7:0]  prevSeg = 8'hFF;

   seven_seg_scanner #(
      .DIGITS   (DIGITS),
      .SCAN_DIV (SCAN_DIV)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .data       (data),
      .dp_in      (dpIn),
      .blank_in   (blankIn),
      .load       (load),
      .an         (an),
      .segments   (segments),
      .frame_done (frameDone)
   );

   // Free-running clock, 10 time units per period.
   always #5 clk = ~clk;

   // Edge counter restarted by reset; edge k after release is "Ek".
   always @(posedge clk) begin
      if (rst) edgeCnt <= 0;
      else     edgeCnt <= edgeCnt + 1;
   end

   // Monitor: samples on the falling edge, away from the active edge.
   initial begin
      forever begin
         @(negedge clk);
         if (monitorOn) begin
            assertCount++;
            if (frameDone !== ((edgeCnt > 0) && (edgeCnt % 16 == 0)))
               $display("[TB] FAIL frame_done at E%0d: got %b, expected %b",
                        edgeCnt, frameDone, ((edgeCnt > 0) && (edgeCnt % 16 == 0)));
            if (frameDone !== ((edgeCnt > 0) && (edgeCnt % 16 == 0))) failCount++;
            assertCount++;
            if ($countones(~an) > 1) begin
               failCount++;
               $display("[TB] FAIL an_onehot at E%0d: got an=%b, expected at most one low bit",
                        edgeCnt, an);
            end
            if (an !== prevAn) begin
               assertCount++;
               if (edgeCnt % SCAN_DIV != 0) begin
                  failCount++;
                  $display("[TB] FAIL slot_timing: an changed at E%0d, expected a multiple of %0d",
                           edgeCnt, SCAN_DIV);
               end
               assertCount++;
               if (expQ.size() == 0) begin
                  failCount++;
                  $display("[TB] FAIL unexpected_slot at E%0d: got an=%b seg=%h, expected no change",
                           edgeCnt, an, segments);
               end else begin
                  monExp = expQ.pop_front();
                  if ({an, segments} !== monExp) begin
                     failCount++;
                     $display("[TB] FAIL slot at E%0d: got an=%b seg=%h, expected an=%b seg=%h",
                              edgeCnt, an, segments, monExp[11:8], monExp[7:0]);
                  end
               end
            end else begin
               assertCount++;
               if (segments !== prevSeg) begin
                  failCount++;
                  $display("[TB] FAIL seg_hold at E%0d: got seg=%h, expected %h",
                           edgeCnt, segments, prevSeg);
               end
            end
            prevAn  = an;
            prevSeg = segments;
         end
      end
   end

   // Advance to 1 time unit after edge k.
   task automatic gotoEdge(input int k);
      while (edgeCnt < k) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Queue the expected pattern of the next scan slot.
   task automatic expectSlot(input logic [3:0] expAn, input logic [7:0] expSeg);
      expQ.push_back({expAn, expSeg});
   endtask

   // Present a load on edge k, then scramble the inputs so any direct use
   // of the live inputs would show up.
   task automatic applyStimulus(input logic [15:0] d, input logic [3:0] dp,
                                input logic [3:0] bl, input int k);
      gotoEdge(k - 1);
      data    = d;
      dpIn    = dp;
      blankIn = bl;
      load    = 1'b1;
      gotoEdge(k);
      load    = 1'b0;
      data    = ~d;
      dpIn    = ~dp;
      blankIn = ~bl;
   endtask

   task automatic checkOutput(input string name, input logic [3:0] expAn,
                              input logic [7:0] expSeg, input logic expFd);
      assertCount++;
      if (an !== expAn || segments !== expSeg || frameDone !== expFd) begin
         failCount++;
         $display("[TB] FAIL %s: got an=%b seg=%h fd=%b, expected an=%b seg=%h fd=%b",
                  name, an, segments, frameDone, expAn, expSeg, expFd);
      end
   endtask

   initial begin
      $display("[TB] seven_seg_scanner bench start");
      @(posedge clk);
      #1;
      checkOutput("reset_state", 4'hF, 8'hFF, 1'b0);
      monitorOn = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      // Reset release with all-zero shadow: digit 1 first, at E4.
      expectSlot(4'b1101, ZU);
      expectSlot(4'b1011, ZU);
      expectSlot(4'b0111, ZU);
      expectSlot(4'b1110, 8'h03);
      gotoEdge(1);
      checkOutput("pre_tick_e1", 4'hF, 8'hFF, 1'b0);
      gotoEdge(3);
      checkOutput("pre_tick_e3", 4'hF, 8'hFF, 1'b0);

      // Decode with a decimal point on digit 2.
      expectSlot(4'b1101, 8'h11);
      expectSlot(4'b1011, 8'h02);
      expectSlot(4'b0111, 8'h01);
      expectSlot(4'b1110, 8'h9F);
      applyStimulus(16'h80A1, 4'b0100, 4'b0000, 17);

      // Blank digit 1: anode still driven, segments dark.
      expectSlot(4'b1101, 8'hFF);
      expectSlot(4'b1011, 8'h02);
      expectSlot(4'b0111, 8'h01);
      expectSlot(4'b1110, 8'h9F);
      applyStimulus(16'h80A1, 4'b0100, 4'b0010, 33);

      // Clear everything, then load on the tick edge that selects digit 2.
      expectSlot(4'b1101, ZU);
      applyStimulus(16'h0000, 4'b0000, 4'b0000, 49);
      expectSlot(4'b1011, ZU);
      expectSlot(4'b0111, 8'h9F);
      expectSlot(4'b1110, 8'h9F);
      expectSlot(4'b1101, 8'h9F);
      applyStimulus(16'h1111, 4'b0000, 4'b0000, 56);

      // Remaining decode entries: 2,3,4,b / 5,6,7,9 / C,d,E,F.
      expectSlot(4'b1011, 8'h0D);
      expectSlot(4'b0111, 8'h25);
      expectSlot(4'b1110, 8'hC1);
      expectSlot(4'b1101, 8'h99);
      applyStimulus(16'h234B, 4'b0000, 4'b0000, 69);
      expectSlot(4'b1011, 8'h41);
      expectSlot(4'b0111, 8'h49);
      expectSlot(4'b1110, 8'h19);
      expectSlot(4'b1101, 8'h1F);
      applyStimulus(16'h5679, 4'b0000, 4'b0000, 85);
      expectSlot(4'b1011, 8'h85);
      expectSlot(4'b0111, 8'hE5);
      expectSlot(4'b1110, 8'h71);
      expectSlot(4'b1101, 8'h61);
      applyStimulus(16'hCDEF, 4'b0000, 4'b0000, 101);

`ifdef SEVEN_SEG_LZ_SUPPRESS_EN
      expectSlot(4'b1011, 8'hFF);
      expectSlot(4'b0111, 8'hFF);
      expectSlot(4'b1110, 8'h03);
      expectSlot(4'b1101, 8'h49);
      applyStimulus(16'h0050, 4'b0000, 4'b0000, 117);
      expectSlot(4'b1011, 8'hFF);
      expectSlot(4'b0111, 8'hFF);
      expectSlot(4'b1110, 8'h03);
      expectSlot(4'b1101, 8'hFF);
      applyStimulus(16'h0000, 4'b0000, 4'b0000, 133);
      rstAt = 150;
`else
      rstAt = 118;
`endif

      // Reset in the middle of a slot: dark on the next cycle, shadow cleared.
      gotoEdge(rstAt - 1);
      expectSlot(4'b1111, 8'hFF);
      rst = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("mid_scan_reset", 4'hF, 8'hFF, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      expectSlot(4'b1101, ZU);
      expectSlot(4'b1011, ZU);
      gotoEdge(3);
      checkOutput("post_reset_pre_tick", 4'hF, 8'hFF, 1'b0);
      gotoEdge(10);

      assertCount++;
      if (expQ.size() != 0) begin
         failCount++;
         $display("[TB] FAIL slots_outstanding: got %0d unconsumed, expected 0", expQ.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule

// File: doc/seven_seg_scanner.md
Name: seven_seg_scanner

Overview:
- Time-multiplexed driver for a bank of common-anode seven-segment digits sharing one segment bus.
- Latches a packed hex word, decimal-point and blank masks, then scans the digits round-robin at a programmable rate.
- Decodes the active nibble to the standard active-low segment pattern.
- Sits between the datapath and the board's anode/segment pins, replacing per-digit combinational decoders.

Parameters:
- DIGITS, 8, number of digits scanned (1..16).
- SCAN_DIV, 100000, clk cycles each digit stays lit (>=2).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- data  in  4*DIGITS  packed nibbles; digit i = data[4i+3:4i], digit 0 rightmost.
- dp_in  in  DIGITS  decimal point request per digit, 1 = lit.
- blank_in  in  DIGITS  per-digit blank request, 1 = dark.
- load  in  1  capture data/dp_in/blank_in into shadow registers.
- an  out  DIGITS  anode enables, active-low, at most one bit low.
- segments  out  8  {a,b,c,d,e,f,g,dp}, active-low, bit7=a, bit0=dp.
- frame_done  out  1  one-cycle pulse when digit DIGITS-1's slot ends.

Behaviour:
- Reset (sync, rst=1 at a clk edge):
  - prescaler=0, idx=0, shadow data/dp/blank=0.
  - an=all 1s, segments=8'hFF, frame_done=0.
  - Reset asserted mid-scan aborts the slot immediately; outputs dark on the following cycle.
- Shadow registers:
  - Written on any edge with load=1.
  - Without a load they hold their value; inputs are not used directly.
- Prescaler:
  - Counts 0..SCAN_DIV-1 and wraps.
  - tick=1 when prescaler==SCAN_DIV-1.
- Digit index:
  - On tick, idx advances idx+1; DIGITS-1 wraps to 0.
  - frame_done=1 for exactly the cycle after the tick that wraps idx from DIGITS-1 to 0.
- Output registers:
  - an and segments are registered and update only on the edge where tick=1.
  - They take the new idx (post-increment) and current shadow contents; latency is 1 clk from the tick edge.
  - First lit digit after reset is digit 1, SCAN_DIV cycles after rst deasserts. Digit 0 follows DIGITS-1 slots later.
- Segment decode, abcdefg with dp bits excluded:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110.
  - 4=1001100, 5=0100100, 6=0100000, 7=0001111.
  - 8=0000000, 9=0001100, A=0001000, b=1100000.
  - C=1110010, d=1000010, E=0110000, F=0111000.
  - Bit0 = ~dp.
- Blanking:
  - Digit with blank=1: segments=8'hFF; its an bit is still driven low, which keeps scan timing uniform.
- Simultaneous load and tick:
  - The output register samples the pre-load shadow value.
  - New value appears at the next tick.
- Only one an bit is ever low. Switching happens in a single edge with no overlap.

Optional Feature:
- Macro: SEVEN_SEG_LZ_SUPPRESS_EN.
- Defined: leading-zero suppression.
  - Digits from DIGITS-1 downward whose shadow nibble is 0 are blanked, stopping at the first nonzero nibble or at any digit with dp=1.
  - Digit 0 is never suppressed.
  - Suppression is computed from the shadow registers, so it follows load timing.
- Not defined: every unblanked digit shows its nibble, zeros included.

Test Plan (DIGITS=4, SCAN_DIV=4):
- Reset release:
  - Stimulus: rst high 3 cycles, then low.
  - Response: an=4'hF and segments=8'hFF until the first tick. Then an=4'b1101 appears 4 cycles after rst drops, and an cycles 1011, 0111, 1110 every 4 clks.
- Decode:
  - Stimulus: load data=16'h80A1, dp_in=4'b0100.
  - Response: per slot, digit0 shows 8'h9F, digit1 shows 8'h11, digit2 shows 8'h02, digit3 shows 8'h01.
- Blank:
  - Stimulus: load blank_in=4'b0010.
  - Response: during digit1's slot an=4'b1101 and segments=8'hFF.
- frame_done:
  - Response: exactly one 1-cycle pulse per 16 clks, on the cycle an becomes 4'b1110.
- Load/tick collision:
  - Stimulus: load 16'h1111 on the tick edge that selects digit2, whose old value is 0.
  - Response: that slot shows 8'h03; the next slot (digit3) shows 8'h9F.
- LZ suppress (macro on):
  - Stimulus: load data=16'h0050.
  - Response: digits 3 and 2 show 8'hFF, digit1 shows 8'h49, digit0 shows 8'h03.
  - Stimulus: data=16'h0000.
  - Response: only digit0 lit, showing 8'h03.
